// File: rtl/sysid_check_ctrl.sv
// System-ID checker and round-robin arbiter sharing one sysid slave port between
// an internal ID/timestamp verification sequence and a single external host reader.
module sysid_check_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1542719444,
  parameter int unsigned READ_WAIT      = 0,
  parameter int unsigned RETRY_LIMIT    = 2,
  parameter logic [31:0] RECHECK_PERIOD = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        sysid_address,
  input  logic [31:0] sysid_readdata,
  input  logic        host_req,
  input  logic        host_addr,
  output logic        host_ack,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  input  logic        check_start,
  output logic        check_busy,
  output logic        id_ok,
  output logic        id_fail,
  output logic [7:0]  mismatch_count,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [2:0] CHK_ID_REQ = 3'd0;
  localparam logic [2:0] CHK_TS_REQ = 3'd1;
  localparam logic [2:0] EVAL       = 3'd2;
  localparam logic [2:0] PASS       = 3'd3;
  localparam logic [2:0] FAIL       = 3'd4;

  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT);
  localparam logic [3:0] RETRY_MAX = 4'(RETRY_LIMIT);

  logic [2:0]  state;
  logic        pending;
  logic        discard;
  logic [3:0]  retries;
  logic [31:0] period_cnt;

  logic        active;
  logic        owner_host;
  logic [2:0]  wait_cnt;
  logic        last_host;
  logic [31:0] rdata_hold;

  logic sample_now;
  logic grant_chk;
  logic grant_host;
  logic chk_sample;
  logic chk_take;
  logic words_match;
  logic period_hit;

  // A grant can only be issued while the slave port is idle; ties go to whoever lost last time.
  assign sample_now  = active && (wait_cnt == WAIT_LAST);
  assign grant_chk   = !active && pending && (!host_req || last_host);
  assign grant_host  = !active && host_req && (!pending || !last_host);
  assign chk_sample  = sample_now && !owner_host;
  assign chk_take    = chk_sample && !discard && !check_start;
  assign words_match = (captured_id == EXPECTED_ID) && (captured_ts == EXPECTED_TS);
  assign period_hit  = (RECHECK_PERIOD != 32'd0) && (period_cnt == RECHECK_PERIOD - 32'd1);

  assign host_ack    = !reset && grant_host;
  assign host_rvalid = !reset && sample_now && owner_host;
  assign host_rdata  = host_rvalid ? sysid_readdata : rdata_hold;
  assign check_busy  = reset || ((state != PASS) && (state != FAIL));

  always_ff @(posedge clock) begin
    if (reset) begin
      active        <= 1'b0;
      owner_host    <= 1'b0;
      wait_cnt      <= 3'd0;
      sysid_address <= 1'b0;
      last_host     <= 1'b1;
      rdata_hold    <= 32'd0;
    end else if (!active) begin
      if (grant_chk) begin
        active        <= 1'b1;
        owner_host    <= 1'b0;
        wait_cnt      <= 3'd0;
        sysid_address <= (state == CHK_TS_REQ);
        last_host     <= 1'b0;
      end else if (grant_host) begin
        active        <= 1'b1;
        owner_host    <= 1'b1;
        wait_cnt      <= 3'd0;
        sysid_address <= host_addr;
        last_host     <= 1'b1;
      end
    end else if (sample_now) begin
      active <= 1'b0;
      if (owner_host) begin
        rdata_hold <= sysid_readdata;
      end
    end else begin
      wait_cnt <= wait_cnt + 3'd1;
    end
  end

  // A restart orphans any checker read already on the slave; its sample is dropped via discard.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= CHK_ID_REQ;
      pending        <= 1'b1;
      discard        <= 1'b0;
      retries        <= 4'd0;
      period_cnt     <= 32'd0;
      id_ok          <= 1'b0;
      id_fail        <= 1'b0;
      mismatch_count <= 8'd0;
      captured_id    <= 32'd0;
      captured_ts    <= 32'd0;
    end else begin
      if (grant_chk) begin
        pending <= 1'b0;
      end
      if (chk_sample) begin
        discard <= 1'b0;
      end
      if (check_start) begin
        state      <= CHK_ID_REQ;
        pending    <= 1'b1;
        id_fail    <= 1'b0;
        retries    <= 4'd0;
        period_cnt <= 32'd0;
        discard    <= grant_chk || (active && !owner_host && !sample_now);
      end else begin
        case (state)
          CHK_ID_REQ: begin
            if (chk_take) begin
              captured_id <= sysid_readdata;
              state       <= CHK_TS_REQ;
              pending     <= 1'b1;
            end
          end
          CHK_TS_REQ: begin
            if (chk_take) begin
              captured_ts <= sysid_readdata;
              state       <= EVAL;
            end
          end
          EVAL: begin
            if (words_match) begin
              state      <= PASS;
              id_ok      <= 1'b1;
              retries    <= 4'd0;
              period_cnt <= 32'd0;
            end else begin
              id_ok <= 1'b0;
              if (mismatch_count != 8'hFF) begin
                mismatch_count <= mismatch_count + 8'd1;
              end
              if (retries < RETRY_MAX) begin
                retries <= retries + 4'd1;
                state   <= CHK_ID_REQ;
                pending <= 1'b1;
              end else begin
                state   <= FAIL;
                id_fail <= 1'b1;
              end
            end
          end
          PASS: begin
            if (period_hit) begin
              state      <= CHK_ID_REQ;
              pending    <= 1'b1;
              period_cnt <= 32'd0;
            end else if (RECHECK_PERIOD != 32'd0) begin
              period_cnt <= period_cnt + 32'd1;
            end
          end
          FAIL: begin
          end
          default: begin
            state   <= CHK_ID_REQ;
            pending <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
